spi_peri_continuous: RTL and testbench
======================================

SPI_PERI_CONTINUOUS -- requirements
Module: spi_peri_continuous

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word length in bits (>=2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for dclk/cs/copi (>=2).
REQ-003 SHALL have port clk  input  1  system clock (100 MHz), sole clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_in  input  DATA_WIDTH  next word to return on cipo.
REQ-006 SHALL have port data_in_valid  input  1  data_in offered; accepted when data_in_ready high.
REQ-007 SHALL have port data_in_ready  output  1  transmit holding register empty.
REQ-008 SHALL have port data_out  output  DATA_WIDTH  last complete word received on copi.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse, data_out updated.
REQ-010 SHALL have port busy  output  1  high while cs sampled low.
REQ-011 SHALL have port copi  input  1  controller-out-peripheral-in.
REQ-012 SHALL have port cipo  output  1  controller-in-peripheral-out.
REQ-013 SHALL have port dclk  input  1  SPI data clock from controller.
REQ-014 SHALL have port cs  input  1  chip select, active-low.

Function
REQ-015 SHALL pass dclk, cs, copi through SYNC_STAGES flops, then one edge-detect register; all logic uses synchronized copies only.
REQ-016 SHALL operate SPI mode 0: sample copi on detected dclk rise, advance cipo on detected dclk fall, MSB first.
REQ-017 SHALL support dclk half-period >= SYNC_STAGES+2 clk cycles; slower is unconstrained.
REQ-018 SHALL implement states IDLE and ACTIVE; IDLE->ACTIVE on synchronized cs fall, ACTIVE->IDLE on synchronized cs rise.
REQ-019 SHALL, on each word start (IDLE->ACTIVE, or falling dclk following DATA_WIDTH-th rise while cs low), move holding register into tx shift register and drive its MSB on cipo the next cycle.
REQ-020 SHALL, at word start with holding register empty, transmit all-zeros.
REQ-021 SHALL assert data_in_ready whenever holding register empty; data_in_valid&&data_in_ready loads it next cycle; load and word-start same cycle: shift register takes old content, holding register takes new word.
REQ-022 SHALL count rises 0..DATA_WIDTH-1; on DATA_WIDTH-th rise, data_out <= assembled word and data_valid pulses one cycle later than that rise's detection, counter wraps to 0 with cs still low (back-to-back words, no gap).
REQ-023 SHALL, on cs rise mid-word, discard partial rx word, emit no data_valid, clear counter, keep holding register contents.
REQ-024 SHALL drive cipo 0 in IDLE.
REQ-025 SHALL ignore dclk edges while cs sampled high.
REQ-026 SHALL assert busy in ACTIVE only.

Reset
REQ-027 SHALL on rst asynchronously set: state IDLE, cipo 0, data_out 0, data_valid 0, busy 0, data_in_ready 1, counters/shift/holding/sync registers 0 (cs sync registers 1).
REQ-028 SHALL, if rst released while cs low, remain IDLE until a fresh cs fall.

Configuration
REQ-029 SHALL, with SPI_PERI_UNDERRUN_EN defined, add output tx_underrun (1 bit, reset 0) pulsing one cycle at any word start with empty holding register.
REQ-030 SHALL, without SPI_PERI_UNDERRUN_EN, omit tx_underrun; all other behaviour identical.

Verification (DATA_WIDTH=8, dclk half-period 50 clk)
REQ-031 SHALL cover: data_in=0xA5 loaded, controller sends 0x3C -> data_out=0x3C, one data_valid pulse; controller receives 0xA5.
REQ-032 SHALL cover: cs held low, controller sends 0x01,0x80,0xFF back-to-back, peripheral preloads 0x11,0x22,0x33 -> three data_valid pulses in order; controller receives 0x11,0x22,0x33.
REQ-033 SHALL cover: no data_in loaded, controller sends 0x55 -> controller receives 0x00, data_out=0x55, tx_underrun pulses when SPI_PERI_UNDERRUN_EN defined.
REQ-034 SHALL cover: cs rises after 5 bits of 0xF0 -> no data_valid, busy falls, next full transfer 0x0F -> data_out=0x0F.
REQ-035 SHALL cover: rst asserted mid-word (bit 3) -> all outputs at reset values asynchronously; transfers resume only after new cs fall.
REQ-036 SHALL cover: data_in_valid asserted on word-start cycle with 0x99 held, new 0x77 -> current word sends 0x99, next word 0x77.

Source files
------------

// File: rtl/spi_peri_continuous.sv
// spi_peri_continuous: SPI mode-0 peripheral, all logic in the clk domain, words stream back-to-back while cs is low.
// Latency: data_valid is a one-cycle pulse on the cycle after the last dclk rise is detected. cipo changes on the cycle after a
// detected dclk fall. dclk, cs and copi pass through SYNC_STAGES flops plus one edge register before use.
// Backpressure: one transmit holding register. data_in_ready is high while it is empty. An empty register at word start sends zeros.
//
// Optional feature macro: SPI_PERI_UNDERRUN_EN adds the tx_underrun output.
//
// Ports:
//   clk, rst                     - system clock; asynchronous active-high reset
//   data_in / _valid / _ready    - next word to return to the controller (valid/ready handshake)
//   data_out / data_valid        - last complete received word, plus a one-cycle update pulse
//   busy                         - high while a selected transfer is in progress (ACTIVE)
//   copi, cipo, dclk, cs         - SPI pins. cs is active-low. dclk, cs and copi are asynchronous.
//   tx_underrun (optional)       - one-cycle pulse at each word start with an empty holding register

module spi_peri_continuous #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  input  logic                  copi,
  output logic                  cipo,
  input  logic                  dclk,
  input  logic                  cs
`ifdef SPI_PERI_UNDERRUN_EN
  ,
  output logic                  tx_underrun
`endif
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                  state_q, state_d;

  logic [SYNC_STAGES-1:0]  dclk_sync_q, dclk_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  copi_sync_q, copi_sync_d;
  logic                    dclk_prev_q, dclk_prev_d;
  logic                    cs_prev_q, cs_prev_d;
  // fill_q marks when the synchronizer holds real pin samples instead of reset values.
  logic [SYNC_STAGES:0]    fill_q, fill_d;
  logic                    armed_q, armed_d;

  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    word_pend_q, word_pend_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;
  logic                    cipo_q, cipo_d;
  logic                    underrun_q, underrun_d;

  logic                    dclk_s, cs_s, copi_s;
  logic                    dclk_rise, dclk_fall;
  logic                    cs_fall_det;
  logic                    selected;
  logic                    word_start;
  logic                    tx_shift;
  logic                    rx_sample;
  logic                    load;
  logic [DATA_WIDTH-1:0]   rx_word;

  // Synchronized copies of the pins and edge detection.
  assign dclk_s      = dclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign copi_s      = copi_sync_q[SYNC_STAGES-1];
  assign dclk_rise   = dclk_s & ~dclk_prev_q;
  assign dclk_fall   = ~dclk_s & dclk_prev_q;
  // A cs fall counts only after cs has been seen high on real samples.
  // A cs held low through reset therefore never starts a transfer.
  assign cs_fall_det = armed_q & ~cs_s & cs_prev_q;

  assign selected    = (state_q == ACTIVE) && !cs_s;
  assign word_start  = ((state_q == IDLE) && cs_fall_det) ||
                       (selected && dclk_fall && word_pend_q);
  assign tx_shift    = selected && dclk_fall && !word_pend_q;
  assign rx_sample   = selected && dclk_rise;
  assign load        = data_in_valid && !hold_full_q;
  assign rx_word     = {rx_sh_q[DATA_WIDTH-2:0], copi_s};

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall_det) state_d = ACTIVE;
      ACTIVE:  if (cs_s)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == ACTIVE);
  end

  // Input synchronizers
  always_comb begin
    dclk_sync_d = {dclk_sync_q[SYNC_STAGES-2:0], dclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    dclk_prev_d = dclk_s;
    cs_prev_d   = cs_s;
    fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};
    armed_d     = armed_q | (fill_q[SYNC_STAGES] & cs_s);
  end

  // Datapath
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    rx_sh_d      = rx_sh_q;
    tx_sh_d      = tx_sh_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    word_pend_d  = word_pend_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    cipo_d       = cipo_q;
    underrun_d   = 1'b0;

    // Outside a selected transfer, the partial word is dropped.
    // The holding register is kept.
    if (!selected) begin
      bit_cnt_d   = '0;
      rx_sh_d     = '0;
      tx_sh_d     = '0;
      word_pend_d = 1'b0;
      cipo_d      = 1'b0;
    end

    if (word_start) begin
      tx_sh_d     = hold_full_q ? hold_q : '0;
      cipo_d      = hold_full_q & hold_q[DATA_WIDTH-1];
      hold_full_d = 1'b0;
      word_pend_d = 1'b0;
      underrun_d  = ~hold_full_q;
    end else if (tx_shift) begin
      tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
      cipo_d  = tx_sh_q[DATA_WIDTH-2];
    end

    if (rx_sample) begin
      rx_sh_d = rx_word;
      if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
        data_out_d   = rx_word;
        data_valid_d = 1'b1;
        bit_cnt_d    = '0;
        // The next dclk fall begins the following word.
        word_pend_d  = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    // A load that coincides with a word start refills the register that was just emptied.
    if (load) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      copi_sync_q  <= '0;
      dclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      fill_q       <= '0;
      armed_q      <= 1'b0;
      bit_cnt_q    <= '0;
      rx_sh_q      <= '0;
      tx_sh_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      word_pend_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      cipo_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      dclk_sync_q  <= dclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      copi_sync_q  <= copi_sync_d;
      dclk_prev_q  <= dclk_prev_d;
      cs_prev_q    <= cs_prev_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sh_q      <= rx_sh_d;
      tx_sh_q      <= tx_sh_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      word_pend_q  <= word_pend_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      cipo_q       <= cipo_d;
      underrun_q   <= underrun_d;
    end
  end

  assign data_in_ready = ~hold_full_q;
  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign cipo          = cipo_q;

`ifdef SPI_PERI_UNDERRUN_EN
  assign tx_underrun = underrun_q;
`else
  // The underrun flag has no consumer in this build.
  logic unused_underrun;
  assign unused_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_peri_continuous.sv
`timescale 1ns/1ps

module tb_spi_peri_continuous;

  localparam int HALF  = 50;
  localparam int LIMIT = 5000;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       copi;
  logic       cipo;
  logic       dclk;
  logic       cs;
`ifdef SPI_PERI_UNDERRUN_EN
  logic       tx_underrun;
  int         uc = 0;
`endif

  int checks = 0;
  int errors = 0;
  int dv_count = 0;
  logic [7:0] exp_q[$];

  spi_peri_continuous #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .busy          (busy),
    .copi          (copi),
    .cipo          (cipo),
    .dclk          (dclk),
    .cs            (cs)
`ifdef SPI_PERI_UNDERRUN_EN
    ,
    .tx_underrun   (tx_underrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every data_valid pulse must match the oldest word the controller finished.
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      logic [7:0] e;
      dv_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: data_valid with data_out=%02h, no word expected", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL scoreboard_data: data_out=%02h expected %02h", data_out, e);
        end
      end
    end
  end

`ifdef SPI_PERI_UNDERRUN_EN
  always @(negedge clk) if (!rst && tx_underrun) uc++;
`endif

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one word and hold it until the DUT accepts it.
  task automatic load_word(input logic [7:0] w);
    int n;
    n = 0;
    data_in = w;
    data_in_valid = 1'b1;
    while (!data_in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("FAIL load_timeout: word %02h not accepted in %0d cycles", w, LIMIT);
    end
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  // Mode-0 controller: put copi up, wait half a period, sample cipo, then pulse dclk.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      copi = tx[7-i];
      wait_cyc(HALF);
      rx = {rx[6:0], cipo};
      dclk = 1'b1;
      wait_cyc(HALF);
      dclk = 1'b0;
    end
  endtask

  task automatic cs_assert();
    cs = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic cs_release();
    wait_cyc(HALF);
    cs = 1'b1;
    wait_cyc(2*HALF);
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_valid: %0d expected words never reported", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(3);
    checks++;
    if ({data_in_ready, busy, cipo, data_valid, data_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_values: ready=%b busy=%b cipo=%b valid=%b out=%02h expected 1 0 0 0 00",
               data_in_ready, busy, cipo, data_valid, data_out);
    end
`ifdef SPI_PERI_UNDERRUN_EN
    checks++;
    if (tx_underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_underrun: %b expected 0", tx_underrun);
    end
`endif
    rst = 1'b0;
    wait_cyc(10);
  endtask

  task automatic test_single();
    logic [7:0] rx;
    int dv0;
    load_word(8'hA5);
    checks++;
    if (data_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_full: data_in_ready=%b expected 0", data_in_ready);
    end
    dv0 = dv_count;
    exp_q.push_back(8'h3C);
    cs = 1'b0;
    wait_cyc(10);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: busy=%b expected 1", busy);
    end
    wait_cyc(HALF - 10);
    xfer_bits(8'h3C, 8, rx);
    cs_release();
    checks++;
    if (rx !== 8'hA5) begin
      errors++;
      $display("FAIL single_cipo: controller got %02h expected a5", rx);
    end
    checks++;
    if (dv_count - dv0 != 1) begin
      errors++;
      $display("FAIL single_pulses: %0d data_valid pulses expected 1", dv_count - dv0);
    end
    checks++;
    if (data_out !== 8'h3C || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_out: data_out=%02h busy=%b expected 3c 0", data_out, busy);
    end
    check_queue_empty("single");
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx [3];
    logic [7:0] txw [3];
    logic [7:0] exw [3];
    int dv0;
    txw[0] = 8'h01; txw[1] = 8'h80; txw[2] = 8'hFF;
    exw[0] = 8'h11; exw[1] = 8'h22; exw[2] = 8'h33;
    load_word(8'h11);
    dv0 = dv_count;
    for (int i = 0; i < 3; i++) exp_q.push_back(txw[i]);
    fork
      begin
        load_word(8'h22);
        load_word(8'h33);
      end
      begin
        cs_assert();
        for (int i = 0; i < 3; i++) xfer_bits(txw[i], 8, rx[i]);
        cs_release();
      end
    join
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx[i] !== exw[i]) begin
        errors++;
        $display("FAIL b2b_cipo_%0d: controller got %02h expected %02h", i, rx[i], exw[i]);
      end
    end
    checks++;
    if (dv_count - dv0 != 3) begin
      errors++;
      $display("FAIL b2b_pulses: %0d data_valid pulses expected 3", dv_count - dv0);
    end
    check_queue_empty("b2b");
  endtask

  task automatic test_underrun();
    logic [7:0] rx;
`ifdef SPI_PERI_UNDERRUN_EN
    int uc0;
    uc0 = uc;
`endif
    exp_q.push_back(8'h55);
    cs = 1'b0;
    wait_cyc(10);
`ifdef SPI_PERI_UNDERRUN_EN
    // The first word start happens within a few cycles of cs falling.
    checks++;
    if (uc - uc0 != 1) begin
      errors++;
      $display("FAIL underrun_pulse: %0d pulses at word start expected 1", uc - uc0);
    end
`endif
    wait_cyc(HALF - 10);
    xfer_bits(8'h55, 8, rx);
    cs_release();
    checks++;
    if (rx !== 8'h00) begin
      errors++;
      $display("FAIL underrun_cipo: controller got %02h expected 00", rx);
    end
    checks++;
    if (data_out !== 8'h55) begin
      errors++;
      $display("FAIL underrun_out: data_out=%02h expected 55", data_out);
    end
    check_queue_empty("underrun");
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int dv0;
    dv0 = dv_count;
    cs_assert();
    xfer_bits(8'hF0, 5, rx);
    cs_release();
    checks++;
    if (dv_count != dv0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_valid: pulses=%0d busy=%b expected 0 0", dv_count - dv0, busy);
    end
    checks++;
    if (data_out !== 8'h55) begin
      errors++;
      $display("FAIL abort_out_kept: data_out=%02h expected 55", data_out);
    end
    exp_q.push_back(8'h0F);
    cs_assert();
    xfer_bits(8'h0F, 8, rx);
    cs_release();
    checks++;
    if (data_out !== 8'h0F || rx !== 8'h00) begin
      errors++;
      $display("FAIL abort_next: data_out=%02h cipo_word=%02h expected 0f 00", data_out, rx);
    end
    check_queue_empty("abort");
  endtask

  task automatic test_reset_midword();
    logic [7:0] rx;
    int dv0;
    load_word(8'hC3);
    cs_assert();
    xfer_bits(8'hF0, 3, rx);
    wait_cyc(10);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({data_in_ready, busy, cipo, data_valid, data_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL midreset_async: ready=%b busy=%b cipo=%b valid=%b out=%02h expected 1 0 0 0 00",
               data_in_ready, busy, cipo, data_valid, data_out);
    end
    wait_cyc(5);
    rst = 1'b0;
    dv0 = dv_count;
    // cs is still low after reset; the peripheral must ignore this word.
    xfer_bits(8'hAA, 8, rx);
    checks++;
    if (busy !== 1'b0 || dv_count != dv0 || rx !== 8'h00) begin
      errors++;
      $display("FAIL midreset_ignored: busy=%b pulses=%0d cipo_word=%02h expected 0 0 00",
               busy, dv_count - dv0, rx);
    end
    cs_release();
    exp_q.push_back(8'h3C);
    cs_assert();
    xfer_bits(8'h3C, 8, rx);
    cs_release();
    checks++;
    if (data_out !== 8'h3C || dv_count - dv0 != 1 || rx !== 8'h00) begin
      errors++;
      $display("FAIL midreset_resume: out=%02h pulses=%0d cipo_word=%02h expected 3c 1 00",
               data_out, dv_count - dv0, rx);
    end
    check_queue_empty("midreset");
  endtask

  task automatic test_load_on_start();
    logic [7:0] rx0, rx1;
    load_word(8'h99);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    fork
      load_word(8'h77);
      begin
        cs_assert();
        xfer_bits(8'h12, 8, rx0);
        xfer_bits(8'h34, 8, rx1);
        cs_release();
      end
    join
    checks++;
    if (rx0 !== 8'h99) begin
      errors++;
      $display("FAIL loadstart_first: controller got %02h expected 99", rx0);
    end
    checks++;
    if (rx1 !== 8'h77) begin
      errors++;
      $display("FAIL loadstart_second: controller got %02h expected 77", rx1);
    end
    check_queue_empty("loadstart");
  endtask

  initial begin
    rst = 1'b1;
    data_in = 8'h00;
    data_in_valid = 1'b0;
    copi = 1'b0;
    dclk = 1'b0;
    cs = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midword();
    test_load_on_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
